// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM states,
// the "no interrupt" id and the default source count.
package int_ctrl_pkg;

  localparam int NSRC = 6;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_MODE    = 2'd2;
  localparam logic [1:0] ADDR_CLAIM   = 2'd3;

  localparam logic [2:0] ID_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder: index 0 is the highest priority request.
module int_prio_enc import int_ctrl_pkg::*; #(
  parameter int W = 6
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [2:0]   id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = ID_NONE;
    for (int i = W - 1; i >= 0; i--) begin
      valid = valid | req[i];
      id    = req[i] ? 3'(i) : id;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source edge/level capture, masking, fixed priority,
// and a claim/EOI handshake that presents one interrupt at a time to the CPU.
module int_ctrl import int_ctrl_pkg::*; #(
  parameter int NSRC = int_ctrl_pkg::NSRC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] HWInt
);

  localparam logic [NSRC-1:0] ONE_LSB = {{(NSRC-1){1'b0}}, 1'b1};

  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] prev_q;
  logic [2:0]      in_service_q, in_service_d;
  state_e          state_q, state_d;

  logic [NSRC-1:0] cand, rise, w1c, claim_clr, sel_onehot;
  logic            cand_valid;
  logic [2:0]      cand_id;
  logic            wr_en, rd_en, claim_fire, eoi_hit;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:NSRC];

  assign cand       = pending_q & mask_q;
  assign sel_onehot = ONE_LSB << cand_id;

  int_prio_enc #(.W(NSRC)) u_prio_enc (
    .req   (cand),
    .valid (cand_valid),
    .id    (cand_id)
  );

  // Bus decode and register next-state; a new edge beats a same-cycle clear.
  always_comb begin
    wr_en      = sel & we;
    rd_en      = sel & re;
    rise       = irq_src & ~prev_q;
    claim_fire = rd_en && (addr == ADDR_CLAIM) && (state_q == ST_PRESENT) && cand_valid;
    eoi_hit    = wr_en && (addr == ADDR_CLAIM) && (state_q == ST_SERVICE)
                 && (wdata[2:0] == in_service_q);
    w1c        = '0;
    claim_clr  = '0;
    mask_d     = mask_q;
    mode_d     = mode_q;
    if (wr_en && (addr == ADDR_PENDING)) begin
      w1c = wdata[NSRC-1:0];
    end else begin
      w1c = '0;
    end
    if (claim_fire) begin
      claim_clr = sel_onehot & mode_q;
    end else begin
      claim_clr = '0;
    end
    if (wr_en && (addr == ADDR_MASK)) begin
      mask_d = wdata[NSRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_en && (addr == ADDR_MODE)) begin
      mode_d = wdata[NSRC-1:0];
    end else begin
      mode_d = mode_q;
    end
    pending_d = (mode_q & ((pending_q & ~w1c & ~claim_clr) | rise))
              | (~mode_q & irq_src);
  end

  // Claim/EOI state machine.
  always_comb begin
    state_d      = state_q;
    in_service_d = in_service_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_valid) begin
          state_d = ST_PRESENT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESENT: begin
        if (claim_fire) begin
          state_d      = ST_SERVICE;
          in_service_d = cand_id;
        end else if (!cand_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_SERVICE: begin
        if (eoi_hit) begin
          state_d      = ST_IDLE;
          in_service_d = ID_NONE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        in_service_d = ID_NONE;
      end
    endcase
  end

  // CPU-facing outputs, derived only from flops so reset clears them at once.
  always_comb begin
    HWInt = '0;
    if ((state_q == ST_PRESENT) && cand_valid) begin
      HWInt = sel_onehot;
    end else begin
      HWInt = '0;
    end
    case (addr)
      ADDR_PENDING: rdata = 32'(pending_q);
      ADDR_MASK:    rdata = 32'(mask_q);
      ADDR_MODE:    rdata = 32'(mode_q);
      ADDR_CLAIM:   rdata = ((state_q == ST_PRESENT) && cand_valid) ? 32'(cand_id)
                                                                    : 32'(ID_NONE);
      default:      rdata = 32'h0000_0000;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q    <= '0;
      mask_q       <= '0;
      mode_q       <= '0;
      prev_q       <= '0;
      in_service_q <= ID_NONE;
      state_q      <= ST_IDLE;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      prev_q       <= irq_src;
      in_service_q <= in_service_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expectations are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_int_ctrl;

  localparam logic [1:0] A_PEND  = 2'd0;
  localparam logic [1:0] A_MASK  = 2'd1;
  localparam logic [1:0] A_MODE  = 2'd2;
  localparam logic [1:0] A_CLAIM = 2'd3;

  logic        clk = 1'b0;
  logic        rst, sel, we, re;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [5:0]  irq_src, HWInt;

  always #5 clk = ~clk;

  int_ctrl #(.NSRC(6)) dut (
    .clk(clk), .rst(rst), .sel(sel), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .irq_src(irq_src), .HWInt(HWInt)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] e);
    exp_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic observe(input logic [31:0] got);
    exp_t it;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      it = sb.pop_front();
      check(it.tag, got, it.exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hw(input string tag, input logic [5:0] e);
    expect_val(tag, 32'(e));
    observe(32'(HWInt));
  endtask

  task automatic peek(input string tag, input logic [1:0] a, input logic [31:0] e);
    addr = a;
    #1;
    expect_val(tag, e);
    observe(rdata);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    step(1);
    sel = 1'b0; we = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd_reg(input string tag, input logic [1:0] a, input logic [31:0] e);
    sel = 1'b1; re = 1'b1; addr = a;
    #1;
    expect_val(tag, e);
    observe(rdata);
    step(1);
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic pulse(input logic [5:0] m);
    irq_src = m;
    step(1);
    irq_src = 6'd0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = 2'd0; wdata = 32'd0; irq_src = 6'd0;
    step(2);
    hw("rst_hw", 6'h00);
    peek("rst_pend", A_PEND, 32'h0);
    peek("rst_mask", A_MASK, 32'h0);
    peek("rst_mode", A_MODE, 32'h0);
    peek("rst_claim", A_CLAIM, 32'd7);
    rst = 1'b1;
    step(1);

    // basic edge flow and latency
    wr_reg(A_MODE, 32'h3F);
    wr_reg(A_MASK, 32'h3F);
    pulse(6'h08);
    hw("t1_hw_n1", 6'h00);
    rd_reg("t1_pend_n1", A_PEND, 32'h08);
    hw("t1_hw_n2", 6'h08);
    rd_reg("t1_claim", A_CLAIM, 32'd3);
    hw("t1_hw_svc", 6'h00);
    rd_reg("t1_pend_clr", A_PEND, 32'h00);
    wr_reg(A_CLAIM, 32'd3);

    // preemption before claim
    pulse(6'h08);
    step(1);
    hw("t2_hw3", 6'h08);
    pulse(6'h02);
    hw("t2_preempt", 6'h02);
    rd_reg("t2_claim1", A_CLAIM, 32'd1);
    hw("t2_hw_svc", 6'h00);
    rd_reg("t2_pend", A_PEND, 32'h08);
    wr_reg(A_CLAIM, 32'd1);
    hw("t2_idle", 6'h00);
    step(1);
    hw("t2_rep3", 6'h08);
    rd_reg("t2_claim3", A_CLAIM, 32'd3);
    wr_reg(A_CLAIM, 32'd3);

    // level source
    wr_reg(A_MODE, 32'h3E);
    wr_reg(A_MASK, 32'h01);
    irq_src = 6'h01;
    step(1);
    hw("t3_hw_n1", 6'h00);
    step(1);
    hw("t3_hw_n2", 6'h01);
    rd_reg("t3_claim0", A_CLAIM, 32'd0);
    hw("t3_hw_svc", 6'h00);
    rd_reg("t3_pend", A_PEND, 32'h01);
    wr_reg(A_PEND, 32'h01);
    rd_reg("t3_pend_w1c", A_PEND, 32'h01);
    wr_reg(A_CLAIM, 32'd0);
    step(1);
    hw("t3_reassert", 6'h01);
    irq_src = 6'h00;
    step(2);
    hw("t3_drop", 6'h00);
    rd_reg("t3_idle_claim", A_CLAIM, 32'd7);

    // same-cycle set and W1C, wrong-id EOI
    wr_reg(A_MODE, 32'h3F);
    wr_reg(A_MASK, 32'h3F);
    irq_src = 6'h04;
    wr_reg(A_PEND, 32'h04);
    irq_src = 6'h00;
    rd_reg("t4_set_wins", A_PEND, 32'h04);
    hw("t4_hw2", 6'h04);
    rd_reg("t4_claim2", A_CLAIM, 32'd2);
    pulse(6'h10);
    wr_reg(A_CLAIM, 32'd5);
    step(1);
    hw("t4_wrong_eoi", 6'h00);
    rd_reg("t4_svc_claim", A_CLAIM, 32'd7);
    wr_reg(A_CLAIM, 32'd2);
    step(1);
    hw("t4_next4", 6'h10);
    rd_reg("t4_claim4", A_CLAIM, 32'd4);
    wr_reg(A_CLAIM, 32'd4);

    // masking while presenting
    pulse(6'h20);
    step(1);
    hw("t5_hw5", 6'h20);
    wr_reg(A_MASK, 32'h00);
    hw("t5_masked", 6'h00);
    step(1);
    rd_reg("t5_idle_claim", A_CLAIM, 32'd7);
    wr_reg(A_MASK, 32'h3F);
    step(1);
    hw("t5_unmask", 6'h20);

    // asynchronous reset while in service
    rd_reg("t6_claim5", A_CLAIM, 32'd5);
    pulse(6'h01);
    #2;
    rst = 1'b0;
    #1;
    hw("t6_rst_hw", 6'h00);
    peek("t6_rst_pend", A_PEND, 32'h0);
    peek("t6_rst_mask", A_MASK, 32'h0);
    peek("t6_rst_mode", A_MODE, 32'h0);
    peek("t6_rst_claim", A_CLAIM, 32'd7);
    step(1);
    rst = 1'b1;
    wr_reg(A_MASK, 32'h3F);
    wr_reg(A_MODE, 32'h3F);
    step(2);
    hw("t6_post_hw", 6'h00);
    peek("t6_post_claim", A_CLAIM, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
